// File: rtl/bp_lce_resp_arbiter.sv
// N-source LCE response arbiter (fixed priority + starvation breaker, or round-robin) with packet locking and a registered output FIFO.
// Latency: granted beat reaches the FIFO head the next cycle; grants stall whenever the FIFO has no space for the beat.
module bp_fifo #(
  parameter int width_p = 8,
  parameter int els_p   = 2
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic [width_p-1:0] data_i,
  input  logic               v_i,
  output logic               ready_o,
  output logic [width_p-1:0] data_o,
  output logic               v_o,
  input  logic               yumi_i
);
  localparam int ptr_w_lp = $clog2(els_p);
  localparam int cnt_w_lp = $clog2(els_p + 1);

  logic [width_p-1:0]  mem_r [els_p];
  logic [ptr_w_lp-1:0] rd_ptr_r, wr_ptr_r;
  logic [cnt_w_lp-1:0] count_r;
  logic                enq, deq;

  assign v_o     = (count_r != '0);
  assign deq     = v_o & yumi_i;
  // A full FIFO still accepts a beat in a cycle where the head leaves
  assign ready_o = (count_r < cnt_w_lp'(els_p)) | deq;
  assign enq     = v_i & ready_o;
  assign data_o  = mem_r[rd_ptr_r];

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      count_r  <= '0;
      for (int i = 0; i < els_p; i++) mem_r[i] <= '0;
    end else begin
      if (enq) begin
        mem_r[wr_ptr_r] <= data_i;
        wr_ptr_r <= (wr_ptr_r == ptr_w_lp'(els_p - 1)) ? '0 : wr_ptr_r + 1'b1;
      end
      if (deq) rd_ptr_r <= (rd_ptr_r == ptr_w_lp'(els_p - 1)) ? '0 : rd_ptr_r + 1'b1;
      case ({enq, deq})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end
endmodule

module bp_lce_resp_arbiter #(
  parameter int  num_src_p    = 2,
  parameter int  resp_width_p = 128,
  parameter int  els_p        = 2,
  parameter int  arb_mode_p   = 0,
  parameter int  max_wait_p   = 15,
  localparam int src_id_width_lp = (num_src_p > 1) ? $clog2(num_src_p) : 1
) (
  input  logic                              clk_i,
  input  logic                              reset_n_i,
  input  logic [num_src_p*resp_width_p-1:0] resp_i,
  input  logic [num_src_p-1:0]              resp_last_i,
  input  logic [num_src_p-1:0]              resp_v_i,
  output logic [num_src_p-1:0]              resp_yumi_o,
  output logic [resp_width_p-1:0]           resp_o,
  output logic                              resp_last_o,
  output logic [src_id_width_lp-1:0]        resp_src_o,
  output logic                              resp_v_o,
  input  logic                              resp_ready_i,
  output logic                              starve_o
);
  typedef logic [src_id_width_lp-1:0] src_id_t;
  localparam logic [3:0] max_wait_lp = 4'(max_wait_p);
  localparam int         entry_w_lp  = src_id_width_lp + 1 + resp_width_p;

  logic                    space;
  logic                    locked_r;
  src_id_t                 lock_src_r, rr_ptr_r;
  logic [3:0]              wait_cnt_r [num_src_p];
  logic [num_src_p-1:0]    eligible;
  logic                    normal_v, forced_v, rr_v, grant_v;
  src_id_t                 normal_id, forced_id, rr_id, grant_id;
  logic                    grant_last;
  logic [resp_width_p-1:0] grant_data;
  logic [entry_w_lp-1:0]   fifo_in, fifo_out;

  always_comb begin
    int idx;
    idx       = 0;
    eligible  = '0;
    normal_v  = 1'b0;
    normal_id = '0;
    forced_v  = 1'b0;
    forced_id = '0;
    rr_v      = 1'b0;
    rr_id     = '0;
    for (int i = 0; i < num_src_p; i++) begin
      eligible[i] = resp_v_i[i] & (~locked_r | (lock_src_r == src_id_t'(i)));
      if (eligible[i] && !normal_v) begin
        normal_v  = 1'b1;
        normal_id = src_id_t'(i);
      end
      if (eligible[i] && !forced_v && (max_wait_p != 0) && (wait_cnt_r[i] == max_wait_lp)) begin
        forced_v  = 1'b1;
        forced_id = src_id_t'(i);
      end
    end
    // Round-robin search begins one past the last packet's winner
    for (int k = 1; k <= num_src_p; k++) begin
      idx = (int'(rr_ptr_r) + k) % num_src_p;
      if (eligible[idx] && !rr_v) begin
        rr_v  = 1'b1;
        rr_id = src_id_t'(idx);
      end
    end
  end

  always_comb begin
    grant_v  = 1'b0;
    grant_id = '0;
    if (arb_mode_p == 1) begin
      grant_v  = rr_v;
      grant_id = rr_id;
    end else if (forced_v) begin
      grant_v  = 1'b1;
      grant_id = forced_id;
    end else begin
      grant_v  = normal_v;
      grant_id = normal_id;
    end
    grant_v = grant_v & space & reset_n_i;
    resp_yumi_o = '0;
    for (int i = 0; i < num_src_p; i++) resp_yumi_o[i] = grant_v & (grant_id == src_id_t'(i));
  end

  assign starve_o   = (arb_mode_p == 0) & grant_v & forced_v & (forced_id != normal_id);
  assign grant_last = resp_last_i[grant_id];
  assign grant_data = resp_i[int'(grant_id)*resp_width_p +: resp_width_p];
  assign fifo_in    = {grant_id, grant_last, grant_data};

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      locked_r   <= 1'b0;
      lock_src_r <= '0;
      rr_ptr_r   <= src_id_t'(num_src_p - 1);
      for (int i = 0; i < num_src_p; i++) wait_cnt_r[i] <= '0;
    end else begin
      if (grant_v) begin
        locked_r   <= ~grant_last;
        lock_src_r <= grant_id;
        if ((arb_mode_p == 1) && grant_last) rr_ptr_r <= grant_id;
      end
      // Pass-over counting is suspended while a packet holds the arbiter
      for (int i = 0; i < num_src_p; i++) begin
        if (resp_yumi_o[i]) wait_cnt_r[i] <= '0;
        else if ((arb_mode_p == 0) && !locked_r && space && eligible[i] && (wait_cnt_r[i] != max_wait_lp))
          wait_cnt_r[i] <= wait_cnt_r[i] + 4'd1;
      end
    end
  end

  bp_fifo #(.width_p(entry_w_lp), .els_p(els_p)) out_fifo (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .data_i    (fifo_in),
    .v_i       (grant_v),
    .ready_o   (space),
    .data_o    (fifo_out),
    .v_o       (resp_v_o),
    .yumi_i    (resp_ready_i)
  );

  assign {resp_src_o, resp_last_o, resp_o} = fifo_out;
endmodule

// File: tb/tb_bp_lce_resp_arbiter.sv
// Drives a fixed-priority (3 src) and a round-robin (4 src) arbiter with shared stimulus against a queue-based reference model.
module tb_bp_lce_resp_arbiter;
  localparam int W    = 16;
  localparam int MAXW = 3;
  localparam int ELS  = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [W-1:0] dat [4];
  logic [3:0] v = '0, last = '0;
  logic rdy = 1'b0;
  logic [3*W-1:0] f_resp;
  logic [4*W-1:0] r_resp;
  logic [2:0] f_yumi;
  logic [3:0] r_yumi;
  logic [W-1:0] f_out, r_out;
  logic f_last, r_last, f_v, r_v, f_starve, r_starve;
  logic [1:0] f_src, r_src;

  int vectors = 0;
  int fails = 0;

  int n[2] = '{3, 4};
  int mode[2] = '{0, 1};
  bit locked[2];
  int lsrc[2];
  int wcnt[2][4];
  int ptr[2];
  int q0[$];
  int q1[$];
  int ew[2];
  bit est[2];
  bit espace[2];
  logic [3:0] sy0, sy1;
  logic ss0;

  assign f_resp = {dat[2], dat[1], dat[0]};
  assign r_resp = {dat[3], dat[2], dat[1], dat[0]};

  always #5 clk = ~clk;

  bp_lce_resp_arbiter #(.num_src_p(3), .resp_width_p(W), .els_p(ELS), .arb_mode_p(0), .max_wait_p(MAXW)) dut_fix (
    .clk_i(clk), .reset_n_i(rst_n), .resp_i(f_resp), .resp_last_i(last[2:0]), .resp_v_i(v[2:0]),
    .resp_yumi_o(f_yumi), .resp_o(f_out), .resp_last_o(f_last), .resp_src_o(f_src), .resp_v_o(f_v),
    .resp_ready_i(rdy), .starve_o(f_starve));

  bp_lce_resp_arbiter #(.num_src_p(4), .resp_width_p(W), .els_p(ELS), .arb_mode_p(1), .max_wait_p(15)) dut_rr (
    .clk_i(clk), .reset_n_i(rst_n), .resp_i(r_resp), .resp_last_i(last), .resp_v_i(v),
    .resp_yumi_o(r_yumi), .resp_o(r_out), .resp_last_o(r_last), .resp_src_o(r_src), .resp_v_o(r_v),
    .resp_ready_i(rdy), .starve_o(r_starve));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int qsize(input int d);
    return (d == 0) ? q0.size() : q1.size();
  endfunction

  function automatic int qfront(input int d);
    return (d == 0) ? q0[0] : q1[0];
  endfunction

  function automatic bit elig(input int d, input int i);
    return v[i] && (!locked[d] || lsrc[d] == i);
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      locked[d] = 0;
      lsrc[d] = 0;
      ptr[d] = n[d] - 1;
      for (int i = 0; i < 4; i++) wcnt[d][i] = 0;
    end
    q0.delete();
    q1.delete();
  endtask

  task automatic model_eval();
    for (int d = 0; d < 2; d++) begin
      int qs;
      int normal;
      int forced;
      qs = qsize(d);
      normal = -1;
      forced = -1;
      espace[d] = (qs < ELS) || (qs > 0 && rdy);
      ew[d] = -1;
      est[d] = 0;
      if (espace[d]) begin
        if (mode[d] == 0) begin
          for (int i = 0; i < n[d]; i++)
            if (elig(d, i)) begin
              if (normal < 0) normal = i;
              if (forced < 0 && wcnt[d][i] == MAXW) forced = i;
            end
          if (forced >= 0) begin
            ew[d] = forced;
            est[d] = (forced != normal);
          end else ew[d] = normal;
        end else begin
          for (int k = 1; k <= n[d]; k++) begin
            int i;
            i = (ptr[d] + k) % n[d];
            if (ew[d] < 0 && elig(d, i)) ew[d] = i;
          end
        end
      end
    end
  endtask

  task automatic model_update();
    for (int d = 0; d < 2; d++) begin
      int e;
      int w;
      w = ew[d];
      if (qsize(d) > 0 && rdy) begin
        if (d == 0) void'(q0.pop_front()); else void'(q1.pop_front());
      end
      if (w >= 0) begin
        e = (w << 17) | (int'(last[w]) << 16) | int'(dat[w]);
        if (d == 0) q0.push_back(e); else q1.push_back(e);
      end
      if (mode[d] == 0 && !locked[d] && espace[d])
        for (int i = 0; i < n[d]; i++)
          if (elig(d, i) && i != w && wcnt[d][i] < MAXW) wcnt[d][i]++;
      if (w >= 0) begin
        wcnt[d][w] = 0;
        if (last[w]) begin
          locked[d] = 0;
          if (mode[d] == 1) ptr[d] = w;
        end else begin
          locked[d] = 1;
          lsrc[d] = w;
        end
      end
    end
  endtask

  // Called just after a falling edge with inputs applied; returns at the next falling edge.
  task automatic step(input string tag, output logic [3:0] y0, output logic [3:0] y1, output logic st0);
    logic [3:0] oy[2];
    logic ost[2], ov[2], ol[2];
    logic [W-1:0] od[2];
    logic [1:0] osrc[2];
    string nm;
    int e;
    #1;
    model_eval();
    oy[0] = {1'b0, f_yumi}; oy[1] = r_yumi;
    ost[0] = f_starve; ost[1] = r_starve;
    ov[0] = f_v; ov[1] = r_v;
    ol[0] = f_last; ol[1] = r_last;
    od[0] = f_out; od[1] = r_out;
    osrc[0] = f_src; osrc[1] = r_src;
    for (int d = 0; d < 2; d++) begin
      nm = $sformatf("%s.%s", tag, (d == 0) ? "fix" : "rr");
      chk({nm, ".yumi"}, 32'(oy[d]), (ew[d] >= 0) ? (32'd1 << ew[d]) : 32'd0);
      chk({nm, ".starve"}, 32'(ost[d]), 32'(est[d]));
      chk({nm, ".v_o"}, 32'(ov[d]), 32'(qsize(d) > 0));
      if (qsize(d) > 0) begin
        e = qfront(d);
        chk({nm, ".data"}, 32'(od[d]), 32'(e & 16'hFFFF));
        chk({nm, ".last"}, 32'(ol[d]), 32'((e >> 16) & 1));
        chk({nm, ".src"}, 32'(osrc[d]), 32'(e >> 17));
      end
    end
    y0 = oy[0];
    y1 = oy[1];
    st0 = ost[0];
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic drive(input logic [3:0] vv, input logic [3:0] ll, input logic rr);
    v = vv;
    last = ll;
    rdy = rr;
    for (int i = 0; i < 4; i++) dat[i] = W'($urandom);
  endtask

  task automatic do_reset();
    drive(4'b0000, 4'b0000, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    int exp_rr[5];
    int exp_f[8];
    for (int i = 0; i < 4; i++) dat[i] = '0;
    drive(4'b1111, 4'b1111, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst.fix.yumi", 32'(f_yumi), 0);
    chk("rst.rr.yumi", 32'(r_yumi), 0);
    chk("rst.fix.v_o", 32'(f_v), 0);
    chk("rst.rr.v_o", 32'(r_v), 0);
    chk("rst.fix.data", 32'(f_out), 0);
    chk("rst.rr.data", 32'(r_out), 0);
    chk("rst.fix.src", 32'(f_src), 0);
    chk("rst.rr.src", 32'(r_src), 0);
    chk("rst.fix.last", 32'(f_last), 0);
    chk("rst.rr.last", 32'(r_last), 0);
    chk("rst.fix.starve", 32'(f_starve), 0);
    chk("rst.rr.starve", 32'(r_starve), 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    // Basic priority: both valid, then src0 drops
    drive(4'b0011, 4'b1111, 1'b1); step("basic1", sy0, sy1, ss0);
    chk("basic1.fix.first", 32'(sy0), 32'd1);
    drive(4'b0010, 4'b1111, 1'b1); step("basic2", sy0, sy1, ss0);
    chk("basic2.fix.second", 32'(sy0), 32'd2);
    drive(4'b0000, 4'b0000, 1'b1); step("drain", sy0, sy1, ss0); step("drain", sy0, sy1, ss0);

    // Lock: src1 three-beat packet while src0 waits; src1 drops valid mid-packet
    drive(4'b0010, 4'b0000, 1'b1); step("lock1", sy0, sy1, ss0);
    drive(4'b0011, 4'b0000, 1'b1); step("lock2", sy0, sy1, ss0);
    drive(4'b0001, 4'b0000, 1'b1); step("lockhold", sy0, sy1, ss0);
    chk("lockhold.fix.none", 32'(sy0), 32'd0);
    drive(4'b0011, 4'b0010, 1'b1); step("lock3", sy0, sy1, ss0);
    chk("lock3.fix.src1", 32'(sy0), 32'd2);
    drive(4'b0011, 4'b0011, 1'b1); step("lock4", sy0, sy1, ss0);
    chk("lock4.fix.src0", 32'(sy0), 32'd1);
    drive(4'b0000, 4'b0000, 1'b1); step("drain", sy0, sy1, ss0); step("drain", sy0, sy1, ss0);

    // Backpressure: two beats fill the FIFO, then enq+deq in one cycle
    do_reset();
    for (int s = 0; s < 4; s++) begin
      drive(4'b0111, 4'b1111, 1'b0); step("bp", sy0, sy1, ss0);
      chk("bp.fix.yumi", 32'(sy0), (s < 2) ? 32'd1 : 32'd0);
    end
    drive(4'b0111, 4'b1111, 1'b1); step("bp.swap", sy0, sy1, ss0);
    chk("bp.swap.fix", 32'(sy0), 32'd1);
    drive(4'b0111, 4'b1111, 1'b0); step("bp.full", sy0, sy1, ss0);
    chk("bp.full.fix", 32'(sy0), 32'd0);

    // Starvation: src1 forced after three pass-overs, twice
    do_reset();
    exp_f = '{1, 1, 1, 2, 1, 1, 1, 2};
    for (int s = 0; s < 8; s++) begin
      drive(4'b0011, 4'b1111, 1'b1); step("starve", sy0, sy1, ss0);
      chk("starve.fix.yumi", 32'(sy0), 32'(exp_f[s]));
      chk("starve.fix.pulse", 32'(ss0), (s % 4 == 3) ? 32'd1 : 32'd0);
    end

    // Round-robin order, all valid then with src2 idle
    do_reset();
    exp_rr = '{1, 2, 4, 8, 1};
    for (int s = 0; s < 5; s++) begin
      drive(4'b1111, 4'b1111, 1'b1); step("rr.all", sy0, sy1, ss0);
      chk("rr.all.order", 32'(sy1), 32'(exp_rr[s]));
    end
    do_reset();
    exp_rr = '{1, 2, 8, 1, 2};
    for (int s = 0; s < 4; s++) begin
      drive(4'b1011, 4'b1111, 1'b1); step("rr.skip", sy0, sy1, ss0);
      chk("rr.skip.order", 32'(sy1), 32'(exp_rr[s]));
    end

    // Asynchronous reset while src1 holds the lock and one beat sits in the FIFO
    do_reset();
    drive(4'b0010, 4'b0000, 1'b0); step("areset.pre", sy0, sy1, ss0);
    #2 rst_n = 1'b0;
    #1;
    chk("areset.fix.v_o", 32'(f_v), 0);
    chk("areset.rr.v_o", 32'(r_v), 0);
    chk("areset.fix.yumi", 32'(f_yumi), 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    drive(4'b0011, 4'b1111, 1'b1); step("areset.post", sy0, sy1, ss0);
    chk("areset.post.fix", 32'(sy0), 32'd1);
    chk("areset.post.rr", 32'(sy1), 32'd1);

    // Randomised traffic against the reference model
    for (int s = 0; s < 600; s++) begin
      drive(4'($urandom), 4'($urandom) | 4'($urandom), ($urandom_range(0, 3) != 0));
      step("rand", sy0, sy1, ss0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule

// File: doc/bp_lce_resp_arbiter.md
Name: bp_lce_resp_arbiter

Overview:
- Parametrised N-source LCE response arbiter for the LCE top level. It replaces the fixed two-way combinational priority mux that currently merges LCE-request-side and LCE-command-side response sources.
- Adds the following over the current mux:
  - selectable fixed-priority with starvation breaker, or round-robin;
  - multi-beat packet locking;
  - a registered output FIFO that decouples sources from the LCE-CCE response network.
- Sits between the LCE sub-engines (req, cmd, future writeback/uncached engines) and lce_resp_o.

Parameters:
- num_src_p, 2, number of response sources (2..8)
- resp_width_p, 128, width of one response beat (bp_lce_cce_resp_s width in integration)
- els_p, 2, output FIFO depth (>=2)
- arb_mode_p, 0, 0 = fixed priority (src 0 highest), 1 = round-robin
- max_wait_p, 15, fixed mode only: cycles a valid source may be passed over before forced grant; 0 disables
- src_id_width_lp, derived, BSG_SAFE_CLOG2(num_src_p)

Ports:
- clk_i  in  1  clock
- reset_n_i  in  1  asynchronous active-low reset
- resp_i  in  num_src_p*resp_width_p  per-source beat, source i at bits [i*resp_width_p +: resp_width_p]
- resp_last_i  in  num_src_p  beat is final beat of packet
- resp_v_i  in  num_src_p  source beat valid
- resp_yumi_o  out  num_src_p  beat accepted this cycle (one-hot or zero)
- resp_o  out  resp_width_p  head beat
- resp_last_o  out  1  head beat is last
- resp_src_o  out  src_id_width_lp  source index of head beat
- resp_v_o  out  1  head valid
- resp_ready_i  in  1  downstream ready; transfer = resp_v_o & resp_ready_i
- starve_o  out  1  pulses 1 cycle when a starvation-forced grant occurs

Behaviour:
- Reset, asynchronous while reset_n_i=0:
  - FIFO empty; resp_v_o=0; resp_o/resp_last_o/resp_src_o=0; resp_yumi_o=0; starve_o=0.
  - Lock cleared; RR pointer = num_src_p-1 so src 0 wins first; all wait counters 0.
- Space: space = (count < els_p) | (resp_v_o & resp_ready_i). Enqueue on a full FIFO is permitted in a cycle that also dequeues.
- Grant (combinational):
  - Only when space=1; at most one resp_yumi_o bit high.
  - resp_yumi_o[i] only if resp_v_i[i]=1.
  - No grant when space=0.
- Lock:
  - A granted beat with last=0 locks the arbiter to that source.
  - While locked, only that source is eligible. If the locked source drops valid, nothing is granted; the lock holds.
  - A granted beat with last=1 clears the lock.
- Fixed mode:
  - Lowest-index valid eligible source wins.
  - Wait counter wait_cnt[i] is 4 bits, saturating at max_wait_p. It increments each cycle source i is valid, eligible, space=1 and not granted. It clears on grant of i.
  - Starved = (max_wait_p!=0) & (wait_cnt[i]==max_wait_p). The lowest-index starved source overrides normal priority.
  - starve_o=1 in the cycle of such a grant, only if the forced winner differs from the normal winner.
  - Counters freeze while locked.
- Round-robin mode:
  - Search starts at pointer+1 and wraps modulo num_src_p.
  - The pointer updates to the winner only on a granted last=1 beat, so packets are never interleaved.
  - starve_o is held 0.
- Latency:
  - A beat granted in cycle t appears at the FIFO head no earlier than t+1 (registered storage). There is no combinational path from resp_i to resp_o.
  - resp_yumi_o depends combinationally on resp_v_i and resp_ready_i.
- Ordering:
  - FIFO preserves grant order.
  - resp_src_o and resp_last_o travel with each beat.
- Throughput: sustained 1 beat/cycle when resp_ready_i=1.
- Simultaneous enqueue and dequeue: count unchanged.
- Simultaneous grant and lock release: the next cycle is arbitrated normally.
- Reset mid-packet: lock, FIFO contents and counters are discarded. Sources must restart packets.

Test Plan:
- Reset, then src0 and src1 valid with last=1 and resp_ready_i=1, fixed mode → yumi=2'b01 cycle 1, resp_v_o=1 with resp_src_o=0 at cycle 2, src1 granted cycle 2 once src0 drops.
- Lock: src1 sends 3 beats (last on beat 3) while src0 valid → src0 receives no yumi until src1 beat 3 is granted; output order is src1,src1,src1,src0.
- Backpressure: els_p=2, resp_ready_i=0 → exactly 2 yumis, then none; raising resp_ready_i enables simultaneous deq+enq that same cycle, and count stays 2.
- Starvation: fixed mode, max_wait_p=3, src0 continuously valid single beats, src1 valid → src1 granted after 3 pass-overs with starve_o=1 for 1 cycle; wait_cnt[1] then returns to 0.
- Round-robin, num_src_p=4, all valid single-beat → grant sequence 0,1,2,3,0; with src2 idle → 0,1,3,0.
- Async reset asserted mid-packet with FIFO holding 1 beat → resp_v_o and lock clear immediately; after release, first grant goes to src0.
